prism_byte_range_slicer: RTL
============================

Name: prism_byte_range_slicer

Overview:
- Front end of the byte-stuffing datapath. It takes byte-granular segment commands (byte address, byte length, frame markers).
- For each command it issues one word-aligned read request to the memory reader and accepts the returned DATA_WIDTH words.
- It presents each word to the downstream byte data stuffer with per-beat lsbyte/msbyte byte bounds and sof/eof.
- The downstream stuffer has no backpressure, so this block meters the stream entirely from the memory side.

Parameters:
- DATA_WIDTH, 64, datapath width in bits; legal values 32, 64, 128.
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 16, byte length width.
- OFF_WIDTH, $clog2(DATA_WIDTH/8), width of byte offset within a word.

Ports:
- clock  input  1  clock
- resetn  input  1  reset; synchronous, active-low
- cmd_valid  input  1  segment command valid
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_addr  input  ADDR_WIDTH  first byte address of segment
- cmd_len  input  LEN_WIDTH  segment length in bytes
- cmd_sof  input  1  segment starts a frame
- cmd_eof  input  1  segment ends a frame
- rdreq_valid  output  1  read request valid
- rdreq_ready  input  1  read request accepted
- rdreq_addr  output  ADDR_WIDTH  word-aligned address, low OFF_WIDTH bits zero
- rdreq_words  output  LEN_WIDTH-OFF_WIDTH+1  number of words to read
- rd_valid  input  1  read data valid
- rd_ready  output  1  read data accepted
- rd_data  input  DATA_WIDTH  read data word
- o_valid  output  1  beat valid toward stuffer
- o_lsbyte  output  OFF_WIDTH  lowest valid byte lane
- o_msbyte  output  OFF_WIDTH  highest valid byte lane
- o_sof  output  1  first beat of frame
- o_eof  output  1  last beat of frame
- o_data  output  DATA_WIDTH  word passed through unmodified
- busy  output  1  state != IDLE

Behaviour:
- Arithmetic on command accept, latched into registers:
  - B = DATA_WIDTH/8.
  - first_off = cmd_addr[OFF_WIDTH-1:0].
  - end = cmd_addr + cmd_len - 1, computed at ADDR_WIDTH; address wrap at 2^ADDR_WIDTH is not supported.
  - last_off = end[OFF_WIDTH-1:0].
  - nbeats = (end>>OFF_WIDTH) - (cmd_addr>>OFF_WIDTH) + 1.
  - rdreq_addr = cmd_addr with low OFF_WIDTH bits cleared; rdreq_words = nbeats.
- FSM states: IDLE, REQ, DATA.
  - IDLE: cmd_ready=1. On cmd_valid with cmd_len!=0, latch values and go to REQ.
  - IDLE, cmd_len==0: the command is consumed and discarded; no request, no beats, its sof/eof are dropped. Stay in IDLE.
  - REQ: rdreq_valid=1 with stable address and words. On rdreq_ready go to DATA and load beat counter = nbeats.
  - DATA: rd_ready=1. Each rd_valid handshake emits one beat and decrements the counter. The handshake that consumes the final beat returns the FSM to IDLE.
- cmd_ready is combinational: (state==IDLE). A new command is therefore accepted no earlier than the cycle after the last data handshake, leaving one bubble cycle per segment.
- Beat bounds:
  - Single-beat segment: (first_off, last_off).
  - First of several beats: (first_off, B-1).
  - Middle beats: (0, B-1).
  - Last beat: (0, last_off).
- Frame markers:
  - o_sof = 1 only on the first beat of a segment whose latched cmd_sof=1.
  - o_eof = 1 only on the last beat of a segment whose latched cmd_eof=1.
  - Both may be set on the same beat.
- Output timing:
  - All o_* are registered, with latency 1 cycle from the rd handshake.
  - o_valid is low in every cycle not following a handshake, so rd_valid stalls produce gaps.
  - o_lsbyte, o_msbyte, o_sof, o_eof and o_data hold their last value while o_valid=0.
- Reset:
  - resetn=0 forces IDLE; o_valid, o_sof, o_eof, rdreq_valid, rd_ready, busy = 0; o_lsbyte, o_msbyte, o_data = 0; cmd_ready = 0 during reset.
  - Reset mid-segment abandons the segment silently. Draining the memory reader is the requester's responsibility.
- The block never needs to backpressure its output.

Test Plan:
- DATA_WIDTH=64, cmd addr 0x1003 len 3, sof=eof=1 -> rdreq addr 0x1000 words 1; one beat lsbyte 3 msbyte 5 sof=1 eof=1.
- cmd addr 0x1005 len 20, sof=1 eof=0 -> rdreq 0x1000 words 4; beats (5,7 sof) (0,7) (0,7) (0,0 eof=0); 20 bytes total.
- Aligned cmd addr 0x2000 len 16 eof=1 -> words 2; beats (0,7) (0,7 eof); hold rdreq_ready low 5 cycles -> rdreq_valid held, address and words stable, no beats emitted.
- Insert 3-cycle rd_valid gap mid-segment -> o_valid low exactly 3 cycles, counter unchanged, correct last beat; cmd_ready rises the cycle after the final handshake.
- cmd_len=0 with eof=1 -> accepted in 1 cycle, no rdreq, no beats; the next command proceeds normally.
- Assert resetn=0 during DATA with 2 beats remaining -> next cycle state IDLE, all outputs 0; after release a new command produces correct beats.

Source files
------------

// File: rtl/prism_byte_range_slicer.sv
// prism_byte_range_slicer: turns byte-granular segment commands into one word read
// request and a metered stream of beats tagged with lane bounds and frame markers.
module prism_byte_range_slicer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int OFF_WIDTH  = $clog2(DATA_WIDTH/8)
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0]           cmd_len,
  input  logic                           cmd_sof,
  input  logic                           cmd_eof,
  output logic                           rdreq_valid,
  input  logic                           rdreq_ready,
  output logic [ADDR_WIDTH-1:0]          rdreq_addr,
  output logic [LEN_WIDTH-OFF_WIDTH:0]   rdreq_words,
  input  logic                           rd_valid,
  output logic                           rd_ready,
  input  logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           o_valid,
  output logic [OFF_WIDTH-1:0]           o_lsbyte,
  output logic [OFF_WIDTH-1:0]           o_msbyte,
  output logic                           o_sof,
  output logic                           o_eof,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           busy
);
  localparam int WW = LEN_WIDTH - OFF_WIDTH + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0]            state;
  logic [WW-1:0]         cnt;
  logic [OFF_WIDTH-1:0]  first_off, last_off;
  logic                  sof_l, eof_l;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic                  first_beat, last_beat;
  assign end_addr    = cmd_addr + ADDR_WIDTH'(cmd_len) - ADDR_WIDTH'(1);
  // Control outputs are gated by resetn so they drop during reset, not one edge later.
  assign cmd_ready   = resetn && state == IDLE;
  assign rdreq_valid = resetn && state == REQ;
  assign rd_ready    = resetn && state == DATA;
  assign busy        = resetn && state != IDLE;
  assign first_beat  = cnt == rdreq_words;
  assign last_beat   = cnt == WW'(1);
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      first_off   <= '0;
      last_off    <= '0;
      sof_l       <= 1'b0;
      eof_l       <= 1'b0;
      rdreq_addr  <= '0;
      rdreq_words <= '0;
      o_valid     <= 1'b0;
      o_lsbyte    <= '0;
      o_msbyte    <= '0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_data      <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid && cmd_len != '0) begin
          state       <= REQ;
          first_off   <= cmd_addr[OFF_WIDTH-1:0];
          last_off    <= end_addr[OFF_WIDTH-1:0];
          sof_l       <= cmd_sof;
          eof_l       <= cmd_eof;
          rdreq_addr  <= {cmd_addr[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
          rdreq_words <= WW'(end_addr >> OFF_WIDTH) - WW'(cmd_addr >> OFF_WIDTH) + WW'(1);
        end
        REQ: if (rdreq_ready) begin
          state <= DATA;
          cnt   <= rdreq_words;
        end
        DATA: if (rd_valid) begin
          o_valid  <= 1'b1;
          o_lsbyte <= first_beat ? first_off : '0;
          o_msbyte <= last_beat ? last_off : '1;
          o_sof    <= first_beat && sof_l;
          o_eof    <= last_beat && eof_l;
          o_data   <= rd_data;
          cnt      <= cnt - WW'(1);
          state    <= last_beat ? IDLE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
